// File: rtl/sixty_four_entry_register_bank.sv
// rtl/sixty_four_entry_register_bank.sv - 64-entry register storage with write port and sequential clear sweep
module sixty_four_entry_register_bank #(
  parameter int BITS          = 32,
  parameter int ZERO_REGISTER = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  WRITE_ENABLE,
  input  logic [5:0]            WRITE_ADDRESS,
  input  logic [BITS-1:0]       WRITE_DATA,
  output logic                  WRITE_READY,
  input  logic                  CLEAR_START,
  output logic                  BUSY,
  output logic                  CLEAR_DONE,
  output logic [63:0]           WRITTEN,
  output logic [63:0][BITS-1:0] DATA
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              count_q, count_d;
  logic                    done_q, done_d;
  logic [63:0][BITS-1:0]   mem_q;
  logic [63:0]             written_q;
  logic                    write_accept;
  logic                    write_discard;

  // Writes are only taken while idle; the sweep owns the array otherwise.
  assign write_accept  = WRITE_ENABLE && (state_q == IDLE);
  // Entry 0 is a constant zero when the zero register is enabled.
  assign write_discard = (ZERO_REGISTER != 0) && (WRITE_ADDRESS == 6'd0);

  assign WRITE_READY = (state_q == IDLE);
  assign BUSY        = (state_q == SWEEP);
  assign CLEAR_DONE  = done_q;
  assign WRITTEN     = written_q;
  assign DATA        = mem_q;

  // FSM, sweep counter and done pulse registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      count_q <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start a sweep from idle, walk all 64 entries, pulse done on the last one.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CLEAR_START) begin
          state_d = SWEEP;
          count_d = 6'd0;
        end
      end
      SWEEP: begin
        count_d = count_q + 6'd1;
        if (count_q == 6'd63) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 6'd0;
      end
    endcase
  end

  // Storage array and written mask: sweep clears one entry per edge, otherwise accept writes.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mem_q     <= '0;
      written_q <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[count_q]     <= '0;
      written_q[count_q] <= 1'b0;
    end else if (write_accept && !write_discard) begin
      mem_q[WRITE_ADDRESS]     <= WRITE_DATA;
      written_q[WRITE_ADDRESS] <= 1'b1;
    end
  end

endmodule
